// File: rtl/div_arb_pkg.sv
// -----------------------------------------------------------------------------
// div_arb_pkg
// Shared definitions for the divider arbiter:
//   - OPERAND_W        : operand / result width of the shared divider
//   - DIV_ERR_QUOTIENT : quotient returned on divide-by-zero or timeout
//   - div_arb_state_e  : arbiter FSM encoding (IDLE, LOAD, RUN, RESP)
//   - is_zero()        : zero-operand detector used to short-circuit x/0
// Optional feature macro handled by the users of this package:
//   DIV_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package div_arb_pkg;

  localparam int OPERAND_W = 32;

  typedef logic [OPERAND_W-1:0] operand_t;

  localparam operand_t DIV_ERR_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } div_arb_state_e;

  // True when an operand is all zeros (divisor check before touching the divider).
  function automatic logic is_zero(input operand_t value);
    return (value == {OPERAND_W{1'b0}});
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Returns the index of the first
// asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req_valid [NUM_REQ-1:0]  request vector
//   rr_ptr    [IDX_W-1:0]    highest-priority index this round (0..NUM_REQ-1)
//   grant     [IDX_W-1:0]    chosen index (0 when no request is pending)
//   any_req                  at least one request pending
// -----------------------------------------------------------------------------
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  // One spare bit so rr_ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos_s;

  // Walk offsets from farthest to nearest so the nearest pending request,
  // counted from rr_ptr, is the one left in grant.
  always_comb begin
    grant   = {IDX_W{1'b0}};
    any_req = |req_valid;
    pos_s   = {SUM_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos_s = {1'b0, rr_ptr} + SUM_W'(i);
      pos_s = (pos_s >= SUM_W'(NUM_REQ)) ? (pos_s - SUM_W'(NUM_REQ)) : pos_s;
      grant = req_valid[pos_s[IDX_W-1:0]] ? pos_s[IDX_W-1:0] : grant;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one external 32-bit divider between NUM_REQ requesters. Requests are
// arbitrated round-robin, the divider's reset/start/done handshake is
// sequenced, and quotient/remainder are returned with a one-cycle one-hot
// rsp_valid pulse to the served requester. A zero divisor is answered directly
// (quotient all ones, remainder = dividend, rsp_err=1) without starting the
// divider.
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_dividend/req_divisor : packed per-requester requests
//   rsp_valid/rsp_quotient/rsp_remainder/rsp_err : response to the requester
//   busy                                : FSM is outside IDLE
//   div_reset/div_start/div_dividend/div_divisor : drive the divider
//   div_quotient/div_remainder/div_done          : results from the divider
//   timeout_cnt (only with DIV_ARB_TIMEOUT_EN)   : saturating timeout count
//
// Optional feature: define DIV_ARB_TIMEOUT_EN to add a RUN-state watchdog
// (TIMEOUT_CYCLES) and the timeout_cnt output.
//
// Timing: all outputs are registered. The results and rsp_valid are presented
// during the RESP cycle; the divider control lines follow the state they
// belong to (div_start is high exactly during RUN cycles).
// -----------------------------------------------------------------------------
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
`ifdef DIV_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [OPERAND_W*NUM_REQ-1:0]   req_dividend,
  input  logic [OPERAND_W*NUM_REQ-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [OPERAND_W-1:0]           rsp_quotient,
  output logic [OPERAND_W-1:0]           rsp_remainder,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           div_reset,
  output logic                           div_start,
  output logic [OPERAND_W-1:0]           div_dividend,
  output logic [OPERAND_W-1:0]           div_divisor,
  input  logic [OPERAND_W-1:0]           div_quotient,
  input  logic [OPERAND_W-1:0]           div_remainder,
  input  logic                           div_done
`ifdef DIV_ARB_TIMEOUT_EN
  ,
  output logic [7:0]                     timeout_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  // One-hot response vector for a grant index.
  function automatic logic [NUM_REQ-1:0] onehot(input idx_t idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Unpacked views of the packed operand buses.
  operand_t dividend_a [NUM_REQ];
  operand_t divisor_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dividend_a[g] = req_dividend[g*OPERAND_W +: OPERAND_W];
    assign divisor_a[g]  = req_divisor[g*OPERAND_W +: OPERAND_W];
  end

  div_arb_state_e       state_r;
  div_arb_state_e       state_nxt_s;
  idx_t                 rr_ptr_r;
  idx_t                 grant_r;
  idx_t                 pick_s;
  idx_t                 rsp_grant_s;
  idx_t                 ptr_nxt_s;
  logic                 any_req_s;
  operand_t             sel_dividend_s;
  operand_t             sel_divisor_s;
  operand_t             res_quot_s;
  operand_t             res_rem_s;
  logic                 res_err_s;

  logic [NUM_REQ-1:0]   rsp_valid_r;
  operand_t             rsp_quotient_r;
  operand_t             rsp_remainder_r;
  logic                 rsp_err_r;
  logic                 busy_r;
  logic                 div_reset_r;
  logic                 div_start_r;
  operand_t             div_dividend_r;
  operand_t             div_divisor_r;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     run_cnt_r;
  logic [7:0]           timeout_cnt_r;
  logic                 timeout_hit_s;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (pick_s),
    .any_req   (any_req_s)
  );

  assign sel_dividend_s = dividend_a[pick_s];
  assign sel_divisor_s  = divisor_a[pick_s];

  // The served requester drops to lowest priority next round.
  assign ptr_nxt_s = (grant_r == idx_t'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                      : (grant_r + idx_t'(1'b1));

  // Next-state logic and the result values loaded on entry to RESP.
  always_comb begin
    state_nxt_s = state_r;
    rsp_grant_s = grant_r;
    res_quot_s  = rsp_quotient_r;
    res_rem_s   = rsp_remainder_r;
    res_err_s   = rsp_err_r;
`ifdef DIV_ARB_TIMEOUT_EN
    timeout_hit_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          rsp_grant_s = pick_s;
          if (is_zero(sel_divisor_s)) begin
            // Answer x/0 directly; the divider never starts.
            state_nxt_s = RESP;
            res_quot_s  = DIV_ERR_QUOTIENT;
            res_rem_s   = sel_dividend_s;
            res_err_s   = 1'b1;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (div_done) begin
          state_nxt_s = RESP;
          res_quot_s  = div_quotient;
          res_rem_s   = div_remainder;
          res_err_s   = 1'b0;
        end else begin
`ifdef DIV_ARB_TIMEOUT_EN
          if (run_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt_s   = RESP;
            res_quot_s    = DIV_ERR_QUOTIENT;
            res_rem_s     = {OPERAND_W{1'b0}};
            res_err_s     = 1'b1;
            timeout_hit_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
`else
          state_nxt_s = RUN;
`endif
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, pointer, operand and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      rr_ptr_r        <= {IDX_W{1'b0}};
      grant_r         <= {IDX_W{1'b0}};
      rsp_valid_r     <= {NUM_REQ{1'b0}};
      rsp_quotient_r  <= {OPERAND_W{1'b0}};
      rsp_remainder_r <= {OPERAND_W{1'b0}};
      rsp_err_r       <= 1'b0;
      busy_r          <= 1'b0;
      div_reset_r     <= 1'b1;
      div_start_r     <= 1'b0;
      div_dividend_r  <= {OPERAND_W{1'b0}};
      div_divisor_r   <= {OPERAND_W{1'b0}};
    end else begin
      state_r         <= state_nxt_s;
      // Control lines decoded from the next state so they line up with it.
      busy_r          <= (state_nxt_s != IDLE);
      div_reset_r     <= (state_nxt_s != RUN);
      div_start_r     <= (state_nxt_s == RUN);
      rsp_valid_r     <= (state_nxt_s == RESP) ? onehot(rsp_grant_s) : {NUM_REQ{1'b0}};
      rsp_quotient_r  <= res_quot_s;
      rsp_remainder_r <= res_rem_s;
      rsp_err_r       <= res_err_s;
      if ((state_r == IDLE) && any_req_s) begin
        grant_r        <= pick_s;
        div_dividend_r <= sel_dividend_s;
        div_divisor_r  <= sel_divisor_s;
      end
      if (state_r == RESP) begin
        rr_ptr_r <= ptr_nxt_s;
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  // RUN watchdog (cleared outside RUN) and saturating timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_r     <= {CNT_W{1'b0}};
      timeout_cnt_r <= 8'd0;
    end else begin
      run_cnt_r <= (state_r == RUN) ? (run_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
      if (timeout_hit_s && (timeout_cnt_r != 8'hFF)) begin
        timeout_cnt_r <= timeout_cnt_r + 8'd1;
      end
    end
  end

  assign timeout_cnt = timeout_cnt_r;
`endif

  assign rsp_valid     = rsp_valid_r;
  assign rsp_quotient  = rsp_quotient_r;
  assign rsp_remainder = rsp_remainder_r;
  assign rsp_err       = rsp_err_r;
  assign busy          = busy_r;
  assign div_reset     = div_reset_r;
  assign div_start     = div_start_r;
  assign div_dividend  = div_dividend_r;
  assign div_divisor   = div_divisor_r;

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one Divider32bit instance among up to NUM_REQ requesters, for example the PID gain tuner and the speed-to-RPM converter. It arbitrates round-robin, sequences the divider's reset/start/done protocol, and returns quotient and remainder to the granted requester. It also short-circuits divide-by-zero so that the divider never sees a zero divisor. It sits between the control blocks and the divider, in the clk_div domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 64, watchdog limit in clk cycles from div_start to div_done (used only with the optional feature)

Ports:
clk  in  1  divider clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request; held high with operands stable until its rsp_valid
req_dividend  in  32*NUM_REQ  packed dividends; requester i occupies bits [32i+31:32i]
req_divisor  in  32*NUM_REQ  packed divisors, same packing
rsp_valid  out  NUM_REQ  one-cycle, one-hot completion pulse to the served requester
rsp_quotient  out  32  result; valid while rsp_valid is nonzero
rsp_remainder  out  32  result; valid while rsp_valid is nonzero
rsp_err  out  1  divide-by-zero (or timeout) flag; valid while rsp_valid is nonzero
busy  out  1  high in any state other than IDLE
div_reset  out  1  active-high reset to the divider
div_start  out  1  start_division to the divider
div_dividend  out  32  operand to the divider
div_divisor  out  32  operand to the divider
div_quotient  in  32  from the divider
div_remainder  in  32  from the divider
div_done  in  1  division_done from the divider

Behaviour:
- Reset values: rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_err=0, busy=0, div_reset=1, div_start=0, div_dividend=0, div_divisor=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, LOAD, RUN, RESP. Exactly one transaction is in flight at a time.
- IDLE:
  - If any req_valid is high, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch the grant index and that requester's operands into div_dividend and div_divisor.
  - Latched divisor == 0: go to RESP with quotient=32'hFFFF_FFFF, remainder=dividend, err=1. The divider is not touched.
  - Otherwise go to LOAD.
- LOAD: one cycle with div_reset=1 and div_start=0; operands stable. Go to RUN.
- RUN:
  - div_reset=0 and div_start=1 for every cycle spent here.
  - When div_done is sampled high, capture div_quotient and div_remainder, set err=0, drop div_start, go to RESP.
- RESP:
  - One cycle: rsp_valid[grant]=1 and the result registers are presented.
  - Set rr_ptr = grant+1, wrapping modulo NUM_REQ. Assert div_reset=1. Go to IDLE.
- Latency from req_valid sampled in IDLE to the rsp_valid pulse:
  - divide-by-zero: 2 cycles;
  - normal: 3 cycles plus the divider's run time (cycles in RUN until div_done).
- Requester rule: deassert req_valid in the cycle after rsp_valid. If it stays high, it is treated as a new request and competes again at lowest priority.
- req_valid dropped mid-transaction: the division still completes and rsp_valid still pulses. No abort without the optional feature.
- Simultaneous requests: strict rotation. A requester waits at most NUM_REQ-1 transactions.
- div_done seen outside RUN: ignored.
- Reset asserted mid-transaction: return to IDLE immediately, no rsp_valid pulse, div_reset=1.
- Widths: rr_ptr and grant index are $clog2(NUM_REQ) bits. Operands pass through unmodified; no sign handling (unsigned divide).

Optional Feature:
Macro DIV_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - Reaching TIMEOUT_CYCLES without div_done forces RESP with quotient=32'hFFFF_FFFF, remainder=0, err=1. div_reset is asserted for that RESP cycle.
  - An extra output, timeout_cnt (8 bits, saturating, reset 0), counts timeouts.
- Undefined: no counter, no timeout_cnt port; RUN waits indefinitely.

Decomposition:
- Shared package div_arb_pkg holds:
  - state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RESP=2'd3);
  - DIV_ERR_QUOTIENT = 32'hFFFF_FFFF;
  - the operand width 32.
- One natural sub-module: rr_pick (combinational round-robin priority picker, inputs req_valid and rr_ptr, outputs grant index and any_req).
- The divider stays external and is instantiated by the parent.

Test Plan:
- Single request: requester 0 sends 45*7=315 / 100 with a divider model of 33 cycles -> rsp_valid=3'b001, quotient=3, remainder=15, err=0, latency 36 cycles.
- Divide by zero: requester 1 sends 1234 / 0 -> rsp_valid=3'b010 two cycles later, quotient=32'hFFFF_FFFF, remainder=1234, err=1, div_start never high.
- Contention: all three requesters assert in the same cycle with rr_ptr=0 -> served in order 0, 1, 2; with requester 0 re-asserting, order becomes 0, 1, 2, 0; no starvation.
- Pointer wrap: after requester 2 is served, requesters 0 and 2 pending -> 0 is granted next.
- Reset mid-run: reset pulled low during RUN -> no rsp_valid, div_reset=1, busy=0. A fresh request after release completes correctly.
- Timeout (DIV_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=64): divider model never asserts done -> rsp_valid at cycle 64 of RUN with err=1, quotient=32'hFFFF_FFFF, timeout_cnt=1.
